// File: rtl/pc8001_audio_mixer_if.sv
// Mixer channel-control and audio-output bundle. The master drives channel controls; the slave returns audio.
// Output timing is set by the mixer's strobe only: there is no ready or backpressure path.
interface pc8001_audio_mixer_if #(
    parameter int NCH = 3,
    parameter int IW  = 4,
    parameter int OW  = 16
);
    logic [NCH*IW-1:0]     ch_in;
    logic [NCH-1:0]        ch_en;
    logic [NCH*4-1:0]      ch_gain;
    logic [NCH*2-1:0]      ch_pan;
    logic                  mute;
    logic signed [OW-1:0]  audio_l;
    logic signed [OW-1:0]  audio_r;
    logic                  sample_stb;
    logic                  clip;
    logic                  fade_busy;

    modport master (
        output ch_in, ch_en, ch_gain, ch_pan, mute,
        input  audio_l, audio_r, sample_stb, clip, fade_busy
    );

    modport slave (
        input  ch_in, ch_en, ch_gain, ch_pan, mute,
        output audio_l, audio_r, sample_stb, clip, fade_busy
    );
endinterface

// File: rtl/pc8001_audio_mixer.sv
// N-channel mixer: outputs are saturated and faded, and update 3 clk after each divider strobe.
// The design has no backpressure: inputs are sampled only at the strobe, and outputs hold between samples.
module pc8001_audio_mixer #(
    parameter int NCH        = 3,
    parameter int IW         = 4,
    parameter int OW         = 16,
    parameter int SAMPLE_DIV = 1024,
    parameter int FW         = 6
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    pc8001_audio_mixer_if.slave    bus
);
    localparam int TW = IW + 17;
    localparam int SW = TW + $clog2(NCH);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int LW = FW + 1;
    localparam int PW = OW + LW + 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0] LMAX     = LW'(1) << FW;

    localparam logic [1:0] MUTED     = 2'd0;
    localparam logic [1:0] RAMP_UP   = 2'd1;
    localparam logic [1:0] ON        = 2'd2;
    localparam logic [1:0] RAMP_DOWN = 2'd3;

    localparam logic signed [SW-1:0] SMAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic          s0;

    logic [1:0]    state_q, state_d;
    logic [LW-1:0] level_q, level_d;

    logic signed [IW-1:0] ctr    [NCH];
    logic signed [TW-1:0] term_d [NCH];
    logic signed [TW-1:0] term_q [NCH];
    logic [NCH*2-1:0]     pan_q;
    logic                 v1_q;
    logic [LW-1:0]        lvl1_q;

    logic signed [SW-1:0] sum_l_d, sum_r_d, sum_l_q, sum_r_q;
    logic                 v2_q;
    logic [LW-1:0]        lvl2_q;

    logic                 clip_l, clip_r;
    logic signed [OW-1:0] sat_l, sat_r;
    logic signed [PW-1:0] prod_l, prod_r;

    logic signed [OW-1:0] audio_l_q, audio_r_q;
    logic                 clip_q, stb_q;
    logic                 unused_bits;

    assign s0    = (cnt_q == CNT_LAST);
    assign cnt_d = s0 ? '0 : cnt_q + CW'(1);

    // Fade tracks a target of 0 or unity; reversing mid-ramp just changes step direction.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (s0) begin
            if (!bus.mute && level_q != LMAX) begin
                level_d = level_q + LW'(1);
                state_d = (level_q == LMAX - LW'(1)) ? ON : RAMP_UP;
            end else if (bus.mute && level_q != '0) begin
                level_d = level_q - LW'(1);
                state_d = (level_q == LW'(1)) ? MUTED : RAMP_DOWN;
            end else begin
                state_d = bus.mute ? MUTED : ON;
            end
        end
    end

    // Centring an unsigned sample about midscale is just an MSB flip.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            ctr[k]    = {~bus.ch_in[k*IW+IW-1], bus.ch_in[k*IW +: IW-1]};
            term_d[k] = bus.ch_en[k] ? (TW'(ctr[k]) <<< bus.ch_gain[k*4 +: 4]) : '0;
        end
    end

    always_comb begin
        sum_l_d = '0;
        sum_r_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (pan_q[2*k])   sum_l_d = sum_l_d + SW'(term_q[k]);
            if (pan_q[2*k+1]) sum_r_d = sum_r_d + SW'(term_q[k]);
        end
    end

    always_comb begin
        clip_l = (sum_l_q > SMAX) || (sum_l_q < SMIN);
        clip_r = (sum_r_q > SMAX) || (sum_r_q < SMIN);
        sat_l  = clip_l ? (sum_l_q[SW-1] ? OMIN : OMAX) : sum_l_q[OW-1:0];
        sat_r  = clip_r ? (sum_r_q[SW-1] ? OMIN : OMAX) : sum_r_q[OW-1:0];
        prod_l = PW'(sat_l) * PW'($signed({1'b0, lvl2_q}));
        prod_r = PW'(sat_r) * PW'($signed({1'b0, lvl2_q}));
    end

    assign unused_bits = ^{prod_l[FW-1:0], prod_l[PW-1:OW+FW], prod_r[FW-1:0], prod_r[PW-1:OW+FW]};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            state_q   <= MUTED;
            level_q   <= '0;
            for (int k = 0; k < NCH; k++) term_q[k] <= '0;
            pan_q     <= '0;
            v1_q      <= 1'b0;
            lvl1_q    <= '0;
            sum_l_q   <= '0;
            sum_r_q   <= '0;
            v2_q      <= 1'b0;
            lvl2_q    <= '0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            clip_q    <= 1'b0;
            stb_q     <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            level_q <= level_d;
            v1_q    <= s0;
            v2_q    <= v1_q;
            stb_q   <= v2_q;
            if (s0) begin
                for (int k = 0; k < NCH; k++) term_q[k] <= term_d[k];
                pan_q  <= bus.ch_pan;
                lvl1_q <= level_q;
            end
            if (v1_q) begin
                sum_l_q <= sum_l_d;
                sum_r_q <= sum_r_d;
                lvl2_q  <= lvl1_q;
            end
            if (v2_q) begin
                audio_l_q <= prod_l[FW +: OW];
                audio_r_q <= prod_r[FW +: OW];
                clip_q    <= clip_l | clip_r;
            end
        end
    end

    assign bus.audio_l    = audio_l_q;
    assign bus.audio_r    = audio_r_q;
    assign bus.sample_stb = stb_q;
    assign bus.clip       = clip_q;
    assign bus.fade_busy  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
endmodule
